// File: rtl/vga_demo_pkg.sv
// -----------------------------------------------------------------------------
// vga_demo_pkg
// Shared types and constants for the bouncing-square VGA pixel-writer demo:
// canvas size, pixel coordinate/colour types, the top-level state enum and
// the colour-cycle helper.
// -----------------------------------------------------------------------------
package vga_demo_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   typedef logic [2:0] color_t;    // {R,G,B}
   typedef logic [7:0] coord_x_t;  // column 0..159
   typedef logic [6:0] coord_y_t;  // row 0..119

   typedef enum logic [1:0] {
      CLEAR,
      DRAW,
      WAIT,
      ERASE
   } state_t;

   localparam color_t COLOR_RESET = 3'b010;

   // Advance the box colour, skipping 0 so the box never matches the background.
   function automatic color_t next_color(input color_t c);
      return (c == 3'd7) ? 3'd1 : c + 3'd1;
   endfunction

endpackage

// File: rtl/rect_rasterizer.sv
// -----------------------------------------------------------------------------
// rect_rasterizer
// Walks a rectangle one pixel per clock, x inner / y outer, and emits the
// pixel-plot strobe. The first pixel appears on the edge that samples start_i,
// and done_o pulses for one cycle right after the last pixel (plot_o=0 then).
// Start parameters, including the colour, are latched on start_i.
//
// Ports:
//   clk_i, rst_ni          clock, synchronous active-low reset
//   start_i                begin a new rectangle (sampled every clock)
//   x0_i, y0_i             top-left corner
//   width_i, height_i      rectangle size in pixels (>= 1)
//   color_i                colour for the whole rectangle
//   x_o, y_o, color_o      registered pixel outputs, valid while plot_o=1
//   plot_o                 pixel write strobe
//   done_o                 one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module rect_rasterizer
   import vga_demo_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     start_i,
   input  coord_x_t x0_i,
   input  coord_y_t y0_i,
   input  coord_x_t width_i,
   input  coord_y_t height_i,
   input  color_t   color_i,
   output coord_x_t x_o,
   output coord_y_t y_o,
   output color_t   color_o,
   output logic     plot_o,
   output logic     done_o
);

   coord_x_t x_q, x_d, x_start_q, x_start_d, x_end_q, x_end_d;
   coord_y_t y_q, y_d, y_end_q, y_end_d;
   color_t   color_q, color_d;
   logic     plot_q, plot_d, done_q, done_d;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
      x_d       = x_q;
      y_d       = y_q;
      x_start_d = x_start_q;
      x_end_d   = x_end_q;
      y_end_d   = y_end_q;
      color_d   = color_q;
      plot_d    = plot_q;
      done_d    = 1'b0;
      if (start_i) begin
         x_d       = x0_i;
         y_d       = y0_i;
         x_start_d = x0_i;
         x_end_d   = x0_i + width_i - 8'd1;
         y_end_d   = y0_i + height_i - 7'd1;
         color_d   = color_i;
         plot_d    = 1'b1;
      end else if (plot_q) begin
         if (x_q != x_end_q) begin
            x_d = x_q + 8'd1;
         end else if (y_q != y_end_q) begin
            x_d = x_start_q;
            y_d = y_q + 7'd1;
         end else begin
            plot_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // NOTE: reset is sampled on the clock edge (synchronous), and all state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         x_q       <= '0;
         y_q       <= '0;
         x_start_q <= '0;
         x_end_q   <= '0;
         y_end_q   <= '0;
         color_q   <= '0;
         plot_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         x_q       <= x_d;
         y_q       <= y_d;
         x_start_q <= x_start_d;
         x_end_q   <= x_end_d;
         y_end_q   <= y_end_d;
         color_q   <= color_d;
         plot_q    <= plot_d;
         done_q    <= done_d;
      end
   end

   assign x_o     = x_q;
   assign y_o     = y_q;
   assign color_o = color_q;
   assign plot_o  = plot_q;
   assign done_o  = done_q;

endmodule

// File: rtl/vga_demo_top.sv
// -----------------------------------------------------------------------------
// vga_demo_top
// Bouncing-square demo on a 160x120, 3-bit pixel-plot port. Clears the
// canvas, then loops DRAW -> WAIT (frame tick) -> ERASE -> DRAW, moving the
// box one pixel per axis per frame and bouncing off the canvas edges.
//
// Ports:
//   CLOCK_50    clock
//   KEY[0]      synchronous active-low reset
//   KEY[1]      colour-cycle button (active-low, synchronized, press = step)
//   KEY[2]      pause while low (holds the frame counter at terminal count)
//   KEY[3]      unused
//   VGA_X/VGA_Y/VGA_COLOR  pixel coordinate and colour, valid with plot
//   plot        pixel write strobe, one pixel per clock
//
// Build option: define VGA_DEMO_TRAIL_EN to skip the erase raster so the box
// leaves a trail; ERASE then only moves the box.
// -----------------------------------------------------------------------------
module vga_demo_top
   import vga_demo_pkg::*;
#(
   parameter int FRAME_TICKS = 833333,
   parameter int BOX_SIZE    = 4
) (
   input  logic       CLOCK_50,
   input  logic [3:0] KEY,
   output logic [7:0] VGA_X,
   output logic [6:0] VGA_Y,
   output logic [2:0] VGA_COLOR,
   output logic       plot
);

   localparam int TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_TICKS - 1);
   localparam coord_x_t X_LIMIT = coord_x_t'(SCREEN_W - BOX_SIZE);
   localparam coord_y_t Y_LIMIT = coord_y_t'(SCREEN_H - BOX_SIZE);
   localparam coord_x_t BOX_W   = coord_x_t'(BOX_SIZE);
   localparam coord_y_t BOX_H   = coord_y_t'(BOX_SIZE);

   logic rst_n;
   assign rst_n = KEY[0];

   logic unused_key3;
   assign unused_key3 = KEY[3];

   state_t            state_q;
   logic              launch_q;       // fires the CLEAR raster once after reset
   logic [TICK_W-1:0] tick_q;
   coord_x_t          bx_q, bx_d;
   coord_y_t          by_q, by_d;
   logic              dx_q, dx_d;     // 1 = +1, 0 = -1
   logic              dy_q, dy_d;
   color_t            color_q;
   logic              key1_meta_q, key1_sync_q, key1_prev_q;
   logic              key2_meta_q, key2_sync_q;

   logic     rs_start;
   coord_x_t rs_x0, rs_w;
   coord_y_t rs_y0, rs_h;
   color_t   rs_color;
   logic     r_done;
   logic     erase_done;
   logic     tick_end, go_erase;

   assign tick_end = (tick_q == TICK_LAST);
   assign go_erase = (state_q == WAIT) && tick_end && key2_sync_q;

`ifdef VGA_DEMO_TRAIL_EN
   assign erase_done = 1'b1;
`else
   assign erase_done = r_done;
`endif

   // Next position: reverse at the wall and move in the same step.
   always_comb begin
      dx_d = dx_q;
      if (dx_q && bx_q == X_LIMIT)       dx_d = 1'b0;
      else if (!dx_q && bx_q == '0)      dx_d = 1'b1;
      bx_d = dx_d ? bx_q + 8'd1 : bx_q - 8'd1;

      dy_d = dy_q;
      if (dy_q && by_q == Y_LIMIT)       dy_d = 1'b0;
      else if (!dy_q && by_q == '0)      dy_d = 1'b1;
      by_d = dy_d ? by_q + 7'd1 : by_q - 7'd1;
   end

   // Raster launch requests. Each follows the previous raster's done pulse
   // directly, leaving exactly one idle cycle between back-to-back rasters.
   always_comb begin
      rs_start = 1'b0;
      rs_x0    = '0;
      rs_y0    = '0;
      rs_w     = BOX_W;
      rs_h     = BOX_H;
      rs_color = '0;
      case (state_q)
         CLEAR: begin
            if (launch_q) begin
               rs_start = 1'b1;
               rs_w     = coord_x_t'(SCREEN_W);
               rs_h     = coord_y_t'(SCREEN_H);
            end else if (r_done) begin
               rs_start = 1'b1;
               rs_x0    = bx_q;
               rs_y0    = by_q;
               rs_color = color_q;
            end
         end
         WAIT: begin
`ifndef VGA_DEMO_TRAIL_EN
            if (go_erase) begin
               rs_start = 1'b1;
               rs_x0    = bx_q;
               rs_y0    = by_q;
            end
`endif
         end
         ERASE: begin
            if (erase_done) begin
               rs_start = 1'b1;
               rs_x0    = bx_d;
               rs_y0    = by_d;
               rs_color = color_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         state_q     <= CLEAR;
         launch_q    <= 1'b1;
         tick_q      <= '0;
         bx_q        <= '0;
         by_q        <= '0;
         dx_q        <= 1'b1;
         dy_q        <= 1'b1;
         color_q     <= COLOR_RESET;
         key1_meta_q <= 1'b1;
         key1_sync_q <= 1'b1;
         key1_prev_q <= 1'b1;
         key2_meta_q <= 1'b1;
         key2_sync_q <= 1'b1;
      end else begin
         key1_meta_q <= KEY[1];
         key1_sync_q <= key1_meta_q;
         key1_prev_q <= key1_sync_q;
         key2_meta_q <= KEY[2];
         key2_sync_q <= key2_meta_q;
         launch_q    <= 1'b0;

         // Press = falling edge of the synchronized button.
         if (key1_prev_q && !key1_sync_q) color_q <= next_color(color_q);

         case (state_q)
            CLEAR: if (r_done) state_q <= DRAW;
            DRAW:  if (r_done) state_q <= WAIT;
            WAIT: begin
               if (tick_end) begin
                  // Paused: hold at terminal count until KEY[2] is released.
                  if (key2_sync_q) begin
                     tick_q  <= '0;
                     state_q <= ERASE;
                  end
               end else begin
                  tick_q <= tick_q + 1'b1;
               end
            end
            ERASE: begin
               if (erase_done) begin
                  bx_q    <= bx_d;
                  by_q    <= by_d;
                  dx_q    <= dx_d;
                  dy_q    <= dy_d;
                  state_q <= DRAW;
               end
            end
            default: state_q <= CLEAR;
         endcase
      end
   end

   rect_rasterizer u_raster (
      .clk_i    (CLOCK_50),
      .rst_ni   (rst_n),
      .start_i  (rs_start),
      .x0_i     (rs_x0),
      .y0_i     (rs_y0),
      .width_i  (rs_w),
      .height_i (rs_h),
      .color_i  (rs_color),
      .x_o      (VGA_X),
      .y_o      (VGA_Y),
      .color_o  (VGA_COLOR),
      .plot_o   (plot),
      .done_o   (r_done)
   );

endmodule

// File: tb/tb_vga_demo_top.sv
// -----------------------------------------------------------------------------
// tb_vga_demo_top
// Self-checking bench for vga_demo_top. A behavioural model (box position,
// direction and colour as plain integers) predicts every pixel written; the
// bench compares each plot cycle against it, with random colour presses and
// random pause lengths.
// -----------------------------------------------------------------------------
module tb_vga_demo_top;

   localparam int FT = 32;
   localparam int B  = 4;

   logic       clk = 1'b0;
   logic [3:0] key;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_color;
   logic       plot;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model state.
   int mbx, mby, mdx, mdy, mcol;
   int first_x;

   vga_demo_top #(.FRAME_TICKS(FT), .BOX_SIZE(B)) dut (
      .CLOCK_50  (clk),
      .KEY       (key),
      .VGA_X     (vga_x),
      .VGA_Y     (vga_y),
      .VGA_COLOR (vga_color),
      .plot      (plot)
   );

   always #10 clk = ~clk;

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: run did not finish, errors so far %0d", n_err);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic void model_reset();
      mbx = 0; mby = 0; mdx = 1; mdy = 1; mcol = 2;
   endfunction

   function automatic void model_step();
      if (mdx == 1 && mbx == 160 - B) mdx = -1;
      else if (mdx == -1 && mbx == 0) mdx = 1;
      mbx += mdx;
      if (mdy == 1 && mby == 120 - B) mdy = -1;
      else if (mdy == -1 && mby == 0) mdy = 1;
      mby += mdy;
   endfunction

   // Expect a gap-free raster of w*h pixels (x inner), starting within
   // max_wait extra clocks, followed by one plot=0 cycle.
   task automatic raster(input string tag, input int x0, input int y0, input int w,
                         input int h, input int c, input int max_wait);
      int          waited;
      logic        bad;
      logic [18:0] obs, want;
      waited = 0;
      bad    = 1'b0;
      tick();
      while (!plot && waited < max_wait) begin
         tick();
         waited++;
      end
      if (!plot) begin
         check({tag, "_start"}, 32'(plot), 32'd1);
      end else begin
         first_x = int'(vga_x);
         for (int yy = 0; yy < h && !bad; yy++) begin
            for (int xx = 0; xx < w && !bad; xx++) begin
               if (yy != 0 || xx != 0) tick();
               want = {1'b1, 8'(x0 + xx), 7'(y0 + yy), 3'(c)};
               obs  = {plot, vga_x, vga_y, vga_color};
               check(tag, 32'(obs), 32'(want));
               if (obs !== want) bad = 1'b1;
            end
         end
         if (!bad) begin
            tick();
            check({tag, "_gap"}, 32'(plot), 32'd0);
         end
      end
   endtask

   // One animation step starting right after a DRAW's gap cycle.
   task automatic do_step(input logic press, input logic pause);
      logic quiet;
      int   plen;
      if (press) begin
         key[1] = 1'b0;
         repeat (3) tick();
         key[1] = 1'b1;
         mcol = (mcol == 7) ? 1 : mcol + 1;
      end
      if (pause) begin
         plen   = int'($urandom_range(1, 30));
         key[2] = 1'b0;
         quiet  = 1'b1;
         repeat (FT + plen) begin
            tick();
            if (plot) quiet = 1'b0;
         end
         check("pause_quiet", 32'(quiet), 32'd1);
         key[2] = 1'b1;
      end
`ifndef VGA_DEMO_TRAIL_EN
      raster("erase", mbx, mby, B, B, 0, pause ? 2 : FT + 10);
      model_step();
      raster("draw", mbx, mby, B, B, mcol, 0);
`else
      model_step();
      raster("draw", mbx, mby, B, B, mcol, pause ? 3 : FT + 10);
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_plot"},  32'(plot),      32'd0);
      check({tag, "_x"},     32'(vga_x),     32'd0);
      check({tag, "_y"},     32'(vga_y),     32'd0);
      check({tag, "_color"}, 32'(vga_color), 32'd0);
   endtask

   initial begin
      int   waited;
      logic press, pause;

      key = 4'b1110;
      model_reset();
      repeat (3) tick();
      check_reset_outputs("rst");

      // Release reset: CLEAR starts on the very next edge, then the first box.
      key[0] = 1'b1;
      raster("clear", 0, 0, 160, 120, 0, 0);
      raster("draw0", 0, 0, B, B, 2, 0);

      // Six presses: colours 3,4,5,6,7,1 on successive DRAWs.
      for (int i = 0; i < 6; i++) do_step(1'b1, (i == 2));

      // Bounce until bx reaches the right wall, with random presses/pauses.
      for (int s = 0; s < 400 && mbx != 156; s++) begin
         press = ($urandom_range(0, 3) == 0);
         pause = ($urandom_range(0, 3) == 0);
         do_step(press, pause);
      end
      check("bounce_reached", 32'(first_x), 32'd156);
      do_step(1'b0, 1'b0);
      check("bounce_reverse", 32'(first_x), 32'd155);

      // Reset mid-DRAW: next edge gives plot=0 and zero outputs.
`ifndef VGA_DEMO_TRAIL_EN
      raster("erase_pre_rst", mbx, mby, B, B, 0, FT + 10);
`endif
      waited = 0;
      tick();
      while (!plot && waited < FT + 10) begin
         tick();
         waited++;
      end
      check("mid_draw_plot", 32'(plot), 32'd1);
      tick();
      key[0] = 1'b0;
      tick();
      check_reset_outputs("mid_rst");

      // A colour press during reset must be ignored.
      key[1] = 1'b0;
      repeat (2) tick();
      key[1] = 1'b1;
      repeat (3) tick();
      model_reset();
      key[0] = 1'b1;
      raster("clear2", 0, 0, 160, 120, 0, 0);
      raster("draw_after_rst", 0, 0, B, B, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vga_demo_top.md
# vga_demo_top

Self-contained VGA pixel-writer demo for the DE-series board model: clears a 160×120, 3-bit-colour pixel canvas, then animates a bouncing square. It drives the simulator's "pixel plot" port (`VGA_X`/`VGA_Y`/`VGA_COLOR`/`plot`), writing one pixel per clock. It takes pushbutton input from the `KEY` bus and needs no framebuffer.

## Interface
Parameters:
- `FRAME_TICKS`, default 833333: clock cycles between animation steps (60 Hz at 50 MHz).
- `BOX_SIZE`, default 4: square edge length in pixels (1..16).

Ports:
- `CLOCK_50` in 1: the single clock (50 MHz).
- `KEY` in 4: pushbuttons, active-low.
  - `KEY[0]`: reset. One clock; reset is synchronous and active-low.
  - `KEY[1]`: colour-cycle button.
  - `KEY[2]`: pause while held low.
  - `KEY[3]`: unused.
- `VGA_X` out 8: pixel column, 0..159.
- `VGA_Y` out 7: pixel row, 0..119.
- `VGA_COLOR` out 3: pixel colour, {R,G,B}.
- `plot` out 1: pixel write strobe. The pixel is written on every clock where `plot`=1.

## Operation
- States: `CLEAR`, `DRAW`, `WAIT`, `ERASE`.
- `CLEAR` (entered from reset):
  - Raster all 19200 pixels with colour 0.
  - x is the inner loop (0..159), y is the outer loop (0..119).
  - Go to `DRAW`.
- `DRAW`:
  - Raster the box at (bx..bx+BOX_SIZE-1, by..by+BOX_SIZE-1) with register `color`, in the same x-inner order.
  - Go to `WAIT`.
- `WAIT`:
  - Tick counter counts 0..FRAME_TICKS-1.
  - At the terminal count, if the synchronized `KEY[2]`=1: clear the counter and go to `ERASE`.
  - If `KEY[2]`=0: the counter holds at the terminal count (paused).
- `ERASE`:
  - Raster the current box with colour 0.
  - Update the position, then go to `DRAW`.
- Position update, per axis (x limit 160-BOX_SIZE, y limit 120-BOX_SIZE):
  - If dir=+1 and pos==limit, set dir=-1.
  - If dir=-1 and pos==0, set dir=+1.
  - Then pos += dir. The reversal and the move happen in the same step, so the box never leaves the canvas.
- Colour:
  - `KEY[1]` passes through a 2-flop synchronizer.
  - Each falling edge of the synchronized signal (press) sets `color` ← `color`+1, wrapping 7→1 so colour is never 0.
  - A new colour applies from the next `DRAW`; a `DRAW` already in progress keeps its colour.
- Position, direction and colour arithmetic is unsigned, with widths matching the ports.

## Timing
- Outputs are registered. `VGA_X`/`VGA_Y`/`VGA_COLOR` are valid in the same cycle that `plot`=1.
- Raster rate is one pixel per clock, with no gaps inside a raster.
- `plot`=0 in `WAIT` and on the single transition cycle between rasters.
- Reset values:
  - `VGA_X`=0, `VGA_Y`=0, `VGA_COLOR`=0, `plot`=0.
  - bx=by=0, dx=dy=+1, `color`=3'b010, tick counter=0, state=`CLEAR`.
- First `plot` occurs on the 1st clock after `KEY[0]` is released. `CLEAR` occupies 19200 consecutive plot cycles.
- Reset asserted mid-operation: at the next rising edge, every register returns to its reset value and the current raster is abandoned.
- A button press during reset is ignored. The synchronizer flops reset to 1.

## Configuration
- `VGA_DEMO_TRAIL_EN`:
  - Defined: `ERASE` performs no plotting and only updates the position. The box leaves a trail and the `WAIT`→`DRAW` cycle skips BOX_SIZE² erase cycles.
  - Undefined (default): full erase as described above.

## Structure
- Package `vga_demo_pkg`:
  - `SCREEN_W`=160, `SCREEN_H`=120.
  - `color_t` (3-bit).
  - State enum `state_t`.
  - `coord_x_t` (8-bit), `coord_y_t` (7-bit).
- Sub-module `rect_rasterizer`:
  - Inputs: start, x0, y0, width, height, colour.
  - Outputs: x, y, colour, plot, done (one cycle pulse after the last pixel).
  - Reused for `CLEAR` (0,0,160,120), `DRAW` and `ERASE`.
- Top holds the FSM, tick counter, position/direction, synchronizers and colour registers.

## Test plan
- Reset, then release → exactly 19200 plots with colour 0, the first at (0,0) and the last at (159,119). Then 16 plots with colour 2 at x 0..3, y 0..3, then `plot`=0.
- `FRAME_TICKS`=100, run one step → 16 colour-0 plots at (0..3,0..3), then 16 colour-2 plots at (1..4,1..4).
- Run until bx=156 → next step draws at x 155..158. dx reverses, and no plot ever has x>159 or y>119.
- Pulse `KEY[1]` low for 3 clocks, six times → colour sequence 3,4,5,6,7,1 on successive `DRAW`s; colour 0 never appears.
- Hold `KEY[2]` low across the terminal count → no plots while held. Release → `ERASE` begins within 3 clocks.
- Assert `KEY[0]`=0 mid-`DRAW` → next edge gives `plot`=0 and outputs 0. After release, `CLEAR` restarts at (0,0).
